// File: rtl/sram_fifo_ctrl.sv
// Valid/ready byte FIFO that uses an external single-port SRAM as storage and
// drains it through a one-entry output register; one SRAM access per cycle.
module sram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   occupancy,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(2 ** ADDR_W);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_pend_q, rd_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              rd_go_c;
  logic              wr_go_c;

  // Arbitration: a read wins the SRAM port whenever the output side can take data.
  always_comb begin
    rd_go_c    = 1'b0;
    wr_go_c    = 1'b0;
    in_ready   = 1'b0;
    sram_wr_en = 1'b0;
    sram_addr  = wr_ptr_q;
    sram_din   = in_data;

    rd_go_c  = !rst && (count_q != '0) && !rd_pend_q && (!out_valid_q || out_ready);
    in_ready = !rst && (count_q != FULL) && !rd_go_c;
    wr_go_c  = in_valid && in_ready;

    sram_wr_en = wr_go_c;
    sram_addr  = rd_go_c ? rd_ptr_q : wr_ptr_q;
  end

  // Next-state for pointers, SRAM fill level and the output register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_pend_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (rd_go_c) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      count_d   = count_q - CNT_W'(1);
      rd_pend_d = 1'b1;
    end else if (wr_go_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      count_d  = count_q + CNT_W'(1);
    end

    // A capture always lands in an empty slot, so it takes precedence over pop.
    if (rd_pend_q) begin
      out_valid_d = 1'b1;
      out_data_d  = sram_dout;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign occupancy = count_q + CNT_W'(rd_pend_q) + CNT_W'(out_valid_q);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl with a behavioural registered-read SRAM.
module tb_sram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [3:0] occupancy;
  logic       sram_wr_en;
  logic [2:0] sram_addr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout;

  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int wr_hist [8];
  logic hist_en = 1'b0;
  logic push_done;

  sram_fifo_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;

  // simple_sram: write-through-less, registered read of the presented address
  always @(posedge clk) begin
    if (sram_wr_en) mem[sram_addr] <= sram_din;
    sram_dout <= mem[sram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every handshaken pop is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got 0x%0h expected none at %0t", out_data, $time);
      end else begin
        chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    if (hist_en && sram_wr_en) wr_hist[sram_addr]++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 100) begin
      tick();
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 for data 0x%0h", d);
    end else begin
      exp_q.push_back(d);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    chk("drain_occupancy", 32'(occupancy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    push_done = 1'b0;
    for (int i = 0; i < 8; i++) wr_hist[i] = 0;

    // Power-on reset
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(sram_wr_en), 32'd0);
    rst = 1'b0;

    // Empty pop
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("empty_out_valid", 32'(out_valid), 32'd0);
      chk("empty_occupancy", 32'(occupancy), 32'd0);
      chk("empty_wr_en", 32'(sram_wr_en), 32'd0);
      tick();
    end
    chk("empty_in_ready", 32'(in_ready), 32'd1);

    // Fall-through of 0xA5
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    chk("ft_in_ready", 32'(in_ready), 32'd1);
    chk("ft_wr_en", 32'(sram_wr_en), 32'd1);
    exp_q.push_back(8'hA5);
    tick();
    in_valid = 1'b0;
    chk("ft_e0_out_valid", 32'(out_valid), 32'd0);
    chk("ft_e0_occupancy", 32'(occupancy), 32'd1);
    tick();
    chk("ft_e1_out_valid", 32'(out_valid), 32'd0);
    chk("ft_e1_occupancy", 32'(occupancy), 32'd1);
    tick();
    chk("ft_e2_out_valid", 32'(out_valid), 32'd1);
    chk("ft_e2_out_data", 32'(out_data), 32'hA5);
    drain();

    // Fill: 0x01..0x09 fit (8 in SRAM + output register), 0x0A must be refused
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push(8'(i));
    chk("fill_occupancy", 32'(occupancy), 32'd9);
    in_valid = 1'b1;
    in_data  = 8'h0A;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      chk("fill_wr_en", 32'(sram_wr_en), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("fill_pop_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("fill_after_pop_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Arbitration: 10 pushed so far, B1 sits in the output reg, B2..B4 in SRAM
    out_ready = 1'b0;
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    push(8'hB4);
    tick();
    tick();
    chk("arb_occupancy", 32'(occupancy), 32'd4);
    chk("arb_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hB5;
    #1;
    chk("arb_wr_en", 32'(sram_wr_en), 32'd0);
    chk("arb_addr_rd", 32'(sram_addr), 32'd3);
    chk("arb_in_ready", 32'(in_ready), 32'd0);
    tick();
    #1;
    chk("arb_next_in_ready", 32'(in_ready), 32'd1);
    chk("arb_next_wr_en", 32'(sram_wr_en), 32'd1);
    chk("arb_next_addr_wr", 32'(sram_addr), 32'd6);
    exp_q.push_back(8'hB5);
    tick();
    in_valid = 1'b0;
    drain();

    // Reset mid-stream with 5 entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    tick();
    chk("mid_occupancy", 32'(occupancy), 32'd5);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_occupancy", 32'(occupancy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_wr_en", 32'(sram_wr_en), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("mid_after_in_ready", 32'(in_ready), 32'd1);
    push(8'h11);
    drain();

    // Wrap-around: 20 entries with random push gaps and random pop readiness
    hist_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push(8'(i));
        end
        push_done = 1'b1;
      end
      begin
        int n = 0;
        while ((!push_done || exp_q.size() != 0) && n < 3000) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
      end
    join
    hist_en = 1'b0;
    drain();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (wr_hist[i] < 2) begin
        n_err++;
        $display("FAIL wrap_addr_hist: addr %0d written %0d times, expected at least 2", i, wr_hist[i]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
